// File: rtl/pixel_scan_controller.sv
// Pixel scan sequencer: emits signed (x,y) pixel coordinates in raster order for the delay-and-sum path.
// Latency: first pixel valid one cycle after start; one pixel per cycle; DONE occupies one cycle per frame.
// Backpressure: o_valid/i_ready handshake; all outputs registered and held while i_ready is low.
// Optional feature: define SCAN_SERPENTINE_EN for boustrophedon (serpentine) row order.
module pixel_scan_controller #(
    parameter int COLS = 64,
    parameter int ROWS = 48,
    parameter int IW   = $clog2(COLS*ROWS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic                             i_abort,
    input  logic                             i_cont,
    output logic signed [$clog2(COLS)-1:0]   o_p_x,
    output logic signed [$clog2(ROWS)-1:0]   o_p_y,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_first,
    output logic                             o_last,
    output logic [IW-1:0]                    o_pix_idx,
    output logic                             o_busy,
    output logic                             o_frame_done,
    output logic [7:0]                       o_frame_cnt
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    // Coordinate edges as two's complement bit patterns; wrap is done by reloading these.
    localparam logic [XW-1:0] X_MIN  = XW'(-(COLS/2));
    localparam logic [XW-1:0] X_MAX  = XW'(COLS/2 - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_MIN  = YW'(-(ROWS/2));
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [IW-1:0] I_LAST = IW'(COLS*ROWS - 1);
    localparam logic [IW-1:0] I_ONE  = IW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [XW-1:0]   r_x, w_x_nxt;
    logic [YW-1:0]   r_y, w_y_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic            r_valid, r_first, r_last, r_busy, r_done;
    logic            w_first_nxt, w_last_nxt;
    logic            w_row_end;
`ifdef SCAN_SERPENTINE_EN
    // Direction of the current row: 0 = x ascending, 1 = x descending.
    logic            r_dir, w_dir_nxt;
`endif

    // State and all output registers; async reset returns everything to zero / IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SCAN_SERPENTINE_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_state_nxt == S_SCAN);
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
`ifdef SCAN_SERPENTINE_EN
            r_dir   <= w_dir_nxt;
`endif
        end
    end

    // Next-state and next-pixel computation; abort overrides everything and discards the in-flight pixel.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
`ifdef SCAN_SERPENTINE_EN
        w_dir_nxt   = r_dir;
        w_row_end   = r_dir ? (r_x == X_MIN) : (r_x == X_MAX);
`else
        w_row_end   = (r_x == X_MAX);
`endif
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = S_SCAN;
                        w_x_nxt     = X_MIN;
                        w_y_nxt     = Y_MIN;
                        w_idx_nxt   = '0;
`ifdef SCAN_SERPENTINE_EN
                        w_dir_nxt   = 1'b0;
`endif
                    end
                end
                S_SCAN: begin
                    if (i_ready) begin
                        if (r_idx == I_LAST) begin
                            w_state_nxt = S_DONE;
                            w_cnt_nxt   = r_cnt + 8'd1;
                        end else begin
                            w_idx_nxt = r_idx + I_ONE;
                            if (w_row_end) begin
                                w_y_nxt = r_y + Y_ONE;
`ifdef SCAN_SERPENTINE_EN
                                // x stays on the edge; the next row runs the other way.
                                w_dir_nxt = ~r_dir;
`else
                                w_x_nxt = X_MIN;
`endif
                            end else begin
`ifdef SCAN_SERPENTINE_EN
                                w_x_nxt = r_dir ? (r_x - X_ONE) : (r_x + X_ONE);
`else
                                w_x_nxt = r_x + X_ONE;
`endif
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (i_cont) begin
                        w_state_nxt = S_SCAN;
                        w_x_nxt     = X_MIN;
                        w_y_nxt     = Y_MIN;
                        w_idx_nxt   = '0;
`ifdef SCAN_SERPENTINE_EN
                        w_dir_nxt   = 1'b0;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_first_nxt = (w_state_nxt == S_SCAN) && (w_idx_nxt == '0);
        w_last_nxt  = (w_state_nxt == S_SCAN) && (w_idx_nxt == I_LAST);
    end

    assign o_p_x        = r_x;
    assign o_p_y        = r_y;
    assign o_pix_idx    = r_idx;
    assign o_frame_cnt  = r_cnt;
    assign o_valid      = r_valid;
    assign o_first      = r_first;
    assign o_last       = r_last;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Testbench for pixel_scan_controller with a small 4x2 image.
// Latency: cycle-accurate comparison one step after each rising edge.
// Backpressure: i_ready is driven directed and randomized.
module tb_pixel_scan_controller;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int NPIX = COLS * ROWS;
    localparam int IW   = $clog2(NPIX);

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic                          abort = 1'b0;
    logic                          cont = 1'b0;
    logic                          ready = 1'b0;
    logic signed [$clog2(COLS)-1:0] p_x;
    logic signed [$clog2(ROWS)-1:0] p_y;
    logic                          valid, first, last, busy, frame_done;
    logic [IW-1:0]                 pix_idx;
    logic [7:0]                    frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 scanning, 2 frame-done cycle.
    int m_phase = 0;
    int m_idx   = 0;
    int m_cnt   = 0;

    pixel_scan_controller #(.COLS(COLS), .ROWS(ROWS), .IW(IW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_cont       (cont),
        .o_p_x        (p_x),
        .o_p_y        (p_y),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_first      (first),
        .o_last       (last),
        .o_pix_idx    (pix_idx),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Pixel position derived from its scan-order index.
    function automatic void pix_xy(input int idx, output int ex, output int ey);
        int row, col;
        row = idx / COLS;
        col = idx % COLS;
`ifdef SCAN_SERPENTINE_EN
        if (row % 2 == 1) col = COLS - 1 - col;
`endif
        ex = col - COLS / 2;
        ey = row - ROWS / 2;
    endfunction

    task automatic model_edge();
        if (abort) m_phase = 0;
        else if (m_phase == 0) begin
            if (start) begin m_phase = 1; m_idx = 0; end
        end else if (m_phase == 1) begin
            if (ready) begin
                if (m_idx == NPIX - 1) begin m_phase = 2; m_cnt = (m_cnt + 1) % 256; end
                else m_idx++;
            end
        end else begin
            if (cont) begin m_phase = 1; m_idx = 0; end
            else m_phase = 0;
        end
    endtask

    task automatic compare();
        int ex, ey;
        chk("valid", int'(valid), int'(m_phase == 1));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("frame_done", int'(frame_done), int'(m_phase == 2));
        chk("frame_cnt", int'(frame_cnt), m_cnt);
        if (m_phase == 1) begin
            pix_xy(m_idx, ex, ey);
            chk("pix_idx", int'(pix_idx), m_idx);
            chk("p_x", int'(p_x), ex);
            chk("p_y", int'(p_y), ey);
            chk("first", int'(first), int'(m_idx == 0));
            chk("last", int'(last), int'(m_idx == NPIX - 1));
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare shortly after.
    task automatic step(input logic st, input logic ab, input logic co, input logic rd);
        start = st; abort = ab; cont = co; ready = rd;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_first"}, int'(first), 0);
        chk({tag, "_last"}, int'(last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_x"}, int'(p_x), 0);
        chk({tag, "_y"}, int'(p_y), 0);
        chk({tag, "_idx"}, int'(pix_idx), 0);
        chk({tag, "_cnt"}, int'(frame_cnt), 0);
    endtask

    initial begin
        int guard;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single frame, full throughput.
        step(1, 0, 0, 1);
        for (int i = 0; i < NPIX + 3; i++) step(0, 0, 0, 1);

        // Stall three cycles on the second pixel, with a stray start mid-scan.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < NPIX + 2; i++) step(0, 0, 0, 1);

        // Abort at index 5 while ready is high, then restart.
        step(1, 0, 0, 1);
        guard = 0;
        while (m_idx != 5 && guard < 20) begin step(0, 0, 0, 1); guard++; end
        chk("abort_reach_idx5", m_idx, 5);
        step(0, 1, 0, 1);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < NPIX + 2; i++) step(0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 3) != 0));
        step(0, 1, 0, 1);

        // Continuous mode long enough for the frame counter to wrap.
        step(1, 0, 1, 1);
        for (int i = 0; i < 257 * (NPIX + 1); i++) step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < NPIX + 3; i++) step(0, 0, 0, 1);

        // Asynchronous reset in the middle of a scan.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        m_phase = 0; m_idx = 0; m_cnt = 0;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < NPIX + 2; i++) step(0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
